instruction_fetcher: RTL and testbench



---
 rtl/instruction_fetcher_pkg.sv | 32 +++
 rtl/instruction_fetcher_fetch_counter.sv | 27 ++
 rtl/instruction_fetcher.sv | 130 +++++++++++++
 tb/tb_instruction_fetcher.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg
// Shared types and constants for the instruction fetch front end.
//   - fetch_state_t    : fetch sequencer states (FETCH, HOLD, DRAIN)
//   - DEFAULT_RESET_PC : PC loaded when reset is asserted
//   - if_id            : IF/ID pipeline register handed to decode
//   - next_seq_pc      : sequential PC step (wraps modulo 2^64)
// No ports; imported by instruction_fetcher and fetch_counter.
package instruction_fetcher_pkg;

  // Common definitions used across the front end.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // Temporary pipeline storage between fetch and decode.
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
    logic [63:0] inst_counter;
  } if_id;

  // Plain 64-bit add, so 64'hFFFF_FFFF_FFFF_FFFC steps to 0.
  function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/instruction_fetcher_fetch_counter.sv
// fetch_counter
// 64-bit count of instructions delivered to decode since reset.
// Only instantiated when FETCH_INST_COUNTER_EN is defined.
// Ports:
//   clk   in  1   clock
//   reset in  1   synchronous active-high reset, clears the count
//   incr  in  1   one instruction was captured this cycle
//   count out 64  number of instructions delivered before this cycle
module fetch_counter
  import instruction_fetcher_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        incr,
  output logic [63:0] count
);

  // Wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (incr) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher
// Front-end fetch stage. Owns the PC, issues one outstanding request at a
// time on the instruction bus and holds each fetched word in if_id_state
// until decode takes it. Redirects that arrive while a request is in flight
// park the sequencer in DRAIN so the stale response is swallowed.
// Optional feature macro: FETCH_INST_COUNTER_EN (tags each delivered
// instruction with a 64-bit delivery count; otherwise inst_counter is 0).
// Ports:
//   clk            in  1      clock
//   reset          in  1      synchronous active-high reset
//   ireq_valid     out 1      instruction bus request valid
//   ireq_addr      out 64     fetch address (registered)
//   iresp_data_ok  in  1      response completes the outstanding request
//   iresp_data     in  32     instruction word
//   id_ready       in  1      decode consumes if_id_state this cycle
//   redirect_valid in  1      PC redirect from a later stage
//   redirect_pc    in  64     redirect target, used verbatim
//   if_id_state    out if_id  IF/ID pipeline register
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output if_id        if_id_state
);

  fetch_state_t state, state_next;
  logic [63:0]  pc, pc_next;
  logic [63:0]  req_addr, req_addr_next;
  if_id         if_id_next;
  logic         capture;
  logic [63:0]  delivered_count;

`ifdef FETCH_INST_COUNTER_EN
  fetch_counter u_fetch_counter (
    .clk   (clk),
    .reset (reset),
    .incr  (capture),
    .count (delivered_count)
  );
`else
  assign delivered_count = '0;
`endif

  // req_addr is the registered bus address. It tracks pc whenever a fresh
  // request is about to start, and freezes while draining so the in-flight
  // request is never altered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      if_id_state <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_addr    <= req_addr_next;
      if_id_state <= if_id_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    if_id_next    = if_id_state;
    capture       = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          // A response in the same cycle closes the request, so the new
          // target can be issued straight away; otherwise wait it out.
          if (iresp_data_ok) begin
            req_addr_next = redirect_pc;
          end else begin
            state_next = DRAIN;
          end
        end else if (iresp_data_ok) begin
          capture                 = 1'b1;
          if_id_next.inst         = iresp_data;
          if_id_next.inst_pc      = pc;
          if_id_next.valid        = 1'b1;
          if_id_next.inst_counter = delivered_count;
          pc_next                 = next_seq_pc(pc);
          state_next              = HOLD;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end
        if (iresp_data_ok) begin
          state_next    = FETCH;
          req_addr_next = pc_next;
        end
      end
      HOLD: begin
        // A redirect flushes the held instruction even if decode is ready.
        if (redirect_valid) begin
          if_id_next.valid = 1'b0;
          pc_next          = redirect_pc;
          req_addr_next    = redirect_pc;
          state_next       = FETCH;
        end else if (id_ready) begin
          if_id_next.valid = 1'b0;
          req_addr_next    = pc;
          state_next       = FETCH;
        end
      end
      default: begin
        state_next    = FETCH;
        req_addr_next = pc;
      end
    endcase
  end

  assign ireq_valid = !reset && ((state == FETCH) || (state == DRAIN));
  assign ireq_addr  = req_addr;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher
// Directed bench for instruction_fetcher: sequential fetch, decode
// back-pressure, redirects during and at the end of a bus request, reset
// mid-request, PC wrap, and the optional delivery counter
// (FETCH_INST_COUNTER_EN).
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        id_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  if_id        if_id_state;

  int check_count = 0;
  int pass_count  = 0;

  localparam logic [31:0] D0   = 32'h0000_0113;
  localparam logic [31:0] D1   = 32'h0000_0193;
  localparam logic [31:0] D2   = 32'h0000_0213;
  localparam logic [31:0] D3   = 32'h0000_0293;
  localparam logic [31:0] D4   = 32'h1111_0013;
  localparam logic [31:0] D5   = 32'h2222_0013;
  localparam logic [31:0] D6   = 32'h3333_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  instruction_fetcher dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_state    (if_id_state)
  );

  always #5 clk = ~clk;

  // Delivery count expected on the n-th instruction since reset.
  function automatic logic [63:0] expCtr(input logic [63:0] n);
`ifdef FETCH_INST_COUNTER_EN
    return n;
`else
    return 64'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample one time unit after the edge.
  task automatic applyStimulus(input logic ok, input logic [31:0] data,
                               input logic rdy, input logic rv,
                               input logic [63:0] rpc);
    iresp_data_ok  = ok;
    iresp_data     = data;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expectFetch(input string tag, input logic [63:0] addr);
    checkOutput({tag, ".ireq_valid"}, 64'(ireq_valid), 64'd1);
    checkOutput({tag, ".ireq_addr"}, ireq_addr, addr);
    checkOutput({tag, ".valid"}, 64'(if_id_state.valid), 64'd0);
  endtask

  task automatic expectHold(input string tag, input logic [31:0] inst,
                            input logic [63:0] pc, input logic [63:0] ctr);
    checkOutput({tag, ".ireq_valid"}, 64'(ireq_valid), 64'd0);
    checkOutput({tag, ".valid"}, 64'(if_id_state.valid), 64'd1);
    checkOutput({tag, ".inst"}, 64'(if_id_state.inst), 64'(inst));
    checkOutput({tag, ".inst_pc"}, if_id_state.inst_pc, pc);
    checkOutput({tag, ".inst_counter"}, if_id_state.inst_counter, ctr);
  endtask

  initial begin
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("reset.ireq_valid", 64'(ireq_valid), 64'd0);
    checkOutput("reset.ireq_addr", ireq_addr, 64'h8000_0000);
    checkOutput("reset.valid", 64'(if_id_state.valid), 64'd0);
    checkOutput("reset.inst", 64'(if_id_state.inst), 64'd0);
    checkOutput("reset.inst_pc", if_id_state.inst_pc, 64'd0);
    checkOutput("reset.inst_counter", if_id_state.inst_counter, 64'd0);
    reset = 1'b0;
    #1;
    expectFetch("t1.start", 64'h8000_0000);

    // Zero-wait bus, decode always ready: one instruction every 2 cycles
    applyStimulus(1'b1, D0, 1'b1, 1'b0, 64'd0);
    expectHold("t1.a", D0, 64'h8000_0000, expCtr(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'd0);
    expectFetch("t1.b", 64'h8000_0004);
    applyStimulus(1'b1, D1, 1'b1, 1'b0, 64'd0);
    expectHold("t1.c", D1, 64'h8000_0004, expCtr(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'd0);
    expectFetch("t1.d", 64'h8000_0008);
    applyStimulus(1'b1, D2, 1'b1, 1'b0, 64'd0);
    expectHold("t1.e", D2, 64'h8000_0008, expCtr(2));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'd0);
    expectFetch("t1.f", 64'h8000_000C);

    // Latency-3 bus, decode stalls 4 cycles after capture
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 64'd0);
      expectFetch("t2.wait", 64'h8000_000C);
    end
    applyStimulus(1'b1, D3, 1'b0, 1'b0, 64'd0);
    expectHold("t2.cap", D3, 64'h8000_000C, expCtr(3));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 64'd0);
      expectHold("t2.stall", D3, 64'h8000_000C, expCtr(3));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'd0);
    expectFetch("t2.release", 64'h8000_0010);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 64'd0);
    expectFetch("t2.pending", 64'h8000_0010);

    // Reset with a request outstanding abandons it
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 64'd0);
    checkOutput("rst2.ireq_valid", 64'(ireq_valid), 64'd0);
    checkOutput("rst2.ireq_addr", ireq_addr, 64'h8000_0000);
    checkOutput("rst2.inst_pc", if_id_state.inst_pc, 64'd0);
    reset = 1'b0;
    #1;
    expectFetch("rst2.start", 64'h8000_0000);

    // Redirect while the request is pending: old address held, data dropped
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h8000_1000);
    expectFetch("t3.drain0", 64'h8000_0000);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 64'd0);
    expectFetch("t3.drain1", 64'h8000_0000);
    applyStimulus(1'b1, JUNK, 1'b0, 1'b0, 64'd0);
    expectFetch("t3.discard", 64'h8000_1000);
    applyStimulus(1'b1, D4, 1'b0, 1'b0, 64'd0);
    expectHold("t3.cap", D4, 64'h8000_1000, expCtr(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'd0);
    expectFetch("t3.next", 64'h8000_1004);

    // Redirect with data_ok, then redirects in DRAIN: latest wins
    applyStimulus(1'b1, JUNK, 1'b0, 1'b1, 64'h8000_2000);
    expectFetch("t4.same", 64'h8000_2000);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h8000_2500);
    expectFetch("t4.drain0", 64'h8000_2000);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 64'h8000_3000);
    expectFetch("t4.drain1", 64'h8000_2000);
    applyStimulus(1'b1, JUNK, 1'b0, 1'b0, 64'd0);
    expectFetch("t4.discard", 64'h8000_3000);
    applyStimulus(1'b1, D5, 1'b0, 1'b0, 64'd0);
    expectHold("t4.cap", D5, 64'h8000_3000, expCtr(1));

    // Redirect in HOLD beats id_ready; PC wraps past the top
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    expectFetch("t5.redir", 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, D6, 1'b0, 1'b0, 64'd0);
    expectHold("t5.cap", D6, 64'hFFFF_FFFF_FFFF_FFFC, expCtr(2));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'd0);
    expectFetch("t5.wrap", 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
